// File: rtl/event_stretcher_pkg.sv
// Shared definitions for the LED event stretcher: FSM encoding and timing defaults.
package event_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } state_t;

    // Board timing at 50 MHz: ~42 ms on, ~21 ms off.
    localparam int N_DEFAULT     = 21;
    localparam int GAP_N_DEFAULT = 20;

    // Short timing used when simulating so pulses stay a few cycles long.
    localparam int N_SIM     = 3;
    localparam int GAP_N_SIM = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/event_stretcher_edge_detect.sv
// Rising-edge detector: remembers last cycle's level and flags a 0->1 transition.
module edge_detect (
    input  logic clk,
    input  logic n_reset,
    input  logic level_in,
    output logic rise
);

    logic prev;

    // Track the previous level; cleared on reset so a level already high counts as an edge.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level_in;
        end
    end

    assign rise = level_in & ~prev;

endmodule

// File: rtl/event_stretcher.sv
// Event stretcher: queues rising edges of level_in and replays each as a
// 2^N-cycle LED pulse followed by at least a 2^GAP_N-cycle off gap.
module event_stretcher
    import event_stretcher_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int GAP_N      = GAP_N_DEFAULT,
    parameter int CNT_W      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             level_in,
    input  logic             clear_ovf,
    output logic             led_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int TW = max_int(N, GAP_N);
    localparam logic [TW-1:0]    ON_LAST  = {TW{1'b1}} >> (TW - N);
    localparam logic [TW-1:0]    GAP_LAST = {TW{1'b1}} >> (TW - GAP_N);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          ev;
    logic          consume;
    logic          at_max;
    logic          ovf_set;

    edge_detect u_edge_detect (
        .clk      (clk),
        .n_reset  (n_reset),
        .level_in (level_in),
        .rise     (ev)
    );

    assign at_max  = (pending == CNT_MAX);
    assign ovf_set = ev && !consume && at_max;

    // Pending-event count and sticky overflow; a simultaneous arrival and consume cancel out.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (ev && !consume && !at_max) begin
                pending <= pending + CNT_W'(1);
            end else if (!ev && consume) begin
                pending <= pending - CNT_W'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Next-state, timer and consume decode; the timer restarts on every state change.
    always_comb begin
        next_state = state;
        timer_next = timer;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    next_state = ON;
                    timer_next = '0;
                    consume    = 1'b1;
                end
            end
            ON: begin
                if (timer == ON_LAST) begin
                    next_state = GAP;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_next = '0;
                    if (pending != '0) begin
                        next_state = ON;
                        consume    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: begin
                next_state = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // State, timer and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state   <= IDLE;
            timer   <= '0;
            led_out <= ACTIVE_LOW;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            timer   <= timer_next;
            led_out <= (next_state == ON) != ACTIVE_LOW;
            busy    <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_event_stretcher.sv
// Bench for event_stretcher with short simulation timing (8-cycle on, 4-cycle gap, 2-bit counter).
module tb_event_stretcher;
    import event_stretcher_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       level_in;
    logic       clear_ovf;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    typedef struct {
        int on_len;
        int gap;
    } pulse_t;

    pulse_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    event_stretcher #(
        .N          (N_SIM),
        .GAP_N      (GAP_N_SIM),
        .CNT_W      (2),
        .ACTIVE_LOW (1'b0)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .level_in  (level_in),
        .clear_ovf (clear_ovf),
        .led_out   (led_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic lvl, input logic clr);
        level_in  = lvl;
        clear_ovf = clr;
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic expect_pulse(input int on_len, input int gap);
        pulse_t p;
        p.on_len = on_len;
        p.gap    = gap;
        exp_q.push_back(p);
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while ((busy !== 1'b0 || led_out !== 1'b0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    // Pulse monitor: measures each LED pulse and the off time before it.
    initial begin
        logic   prev_led = 1'b0;
        int     on_cnt = 0;
        int     off_cnt = 0;
        int     gap_seen = 0;
        bit     idle_seen = 1'b0;
        bit     idle_between = 1'b0;
        pulse_t e;
        forever begin
            @(negedge clk);
            if (led_out === 1'b1) begin
                if (!prev_led) begin
                    gap_seen     = off_cnt;
                    idle_between = idle_seen;
                    on_cnt       = 0;
                end
                on_cnt++;
            end else begin
                if (prev_led) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_pulse: got pulse of %0d cycles, required none", on_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (on_cnt != e.on_len) begin
                            errors++;
                            $display("[TB] FAIL pulse_len: got %0d expected %0d", on_cnt, e.on_len);
                        end
                        if (e.gap >= 0) begin
                            checks++;
                            if (gap_seen != e.gap || idle_between) begin
                                errors++;
                                $display("[TB] FAIL pulse_gap: got gap %0d idle %0d expected gap %0d idle 0",
                                         gap_seen, idle_between, e.gap);
                            end
                        end
                    end
                    off_cnt   = 0;
                    idle_seen = 1'b0;
                end
                off_cnt++;
                if (busy !== 1'b1) idle_seen = 1'b1;
            end
            prev_led = (led_out === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_reset   = 1'b0;
        level_in  = 1'b1;
        clear_ovf = 1'b0;

        // Reset with level already high, then one event counted after release
        repeat (3) @(negedge clk);
        check_output("rst_led", led_out, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_pending", pending, 0);
        check_output("rst_overflow", overflow, 0);
        expect_pulse(8, -1);
        n_reset = 1'b1;
        apply_stimulus(1, 0);
        check_output("rel_pending", pending, 1);
        check_output("rel_led", led_out, 0);
        apply_stimulus(1, 0);
        check_output("rel_led_on", led_out, 1);
        check_output("rel_pending_consumed", pending, 0);
        repeat (14) apply_stimulus(1, 0);
        check_output("rel_busy_done", busy, 0);
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);

        // Single event with level held high for 30 cycles
        expect_pulse(8, -1);
        apply_stimulus(1, 0);
        check_output("single_pending", pending, 1);
        check_output("single_busy_pre", busy, 0);
        apply_stimulus(1, 0);
        check_output("single_led", led_out, 1);
        repeat (11) apply_stimulus(1, 0);
        check_output("single_busy_last", busy, 1);
        check_output("single_led_gap", led_out, 0);
        apply_stimulus(1, 0);
        check_output("single_busy_fall", busy, 0);
        repeat (16) apply_stimulus(1, 0);
        check_output("single_pending_end", pending, 0);
        check_output("single_busy_end", busy, 0);
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);

        // Three queued events two cycles apart
        expect_pulse(8, -1);
        expect_pulse(8, 4);
        expect_pulse(8, 4);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus((i % 2) == 0, 0);
            if (i == 4) check_output("queue_pending_peak", pending, 2);
        end
        wait_idle("queue_idle", 200);
        check_output("queue_pending_end", pending, 0);

        // Overflow: saturate, clear colliding with a drop, then a plain clear
        expect_pulse(8, -1);
        expect_pulse(8, 4);
        expect_pulse(8, 4);
        expect_pulse(8, 4);
        for (int i = 0; i < 12; i++) begin
            apply_stimulus((i % 2) == 0, i >= 10);
            if (i == 6) begin
                check_output("ovf_pending_full", pending, 3);
                check_output("ovf_not_yet", overflow, 0);
            end
            if (i == 8) begin
                check_output("ovf_pending_sat", pending, 3);
                check_output("ovf_set", overflow, 1);
            end
            if (i == 10) check_output("ovf_set_beats_clear", overflow, 1);
            if (i == 11) begin
                check_output("ovf_cleared", overflow, 0);
                check_output("ovf_pending_hold", pending, 3);
            end
        end
        apply_stimulus(0, 0);
        wait_idle("ovf_idle", 200);
        check_output("ovf_pending_end", pending, 0);

        // Event arriving on the last gap cycle with one event pending
        expect_pulse(8, -1);
        expect_pulse(8, 4);
        expect_pulse(8, 4);
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(i == 0 || i == 2 || i == 13, 0);
            if (i == 12) begin
                check_output("simul_pending_gap", pending, 1);
                check_output("simul_led_gap", led_out, 0);
            end
        end
        check_output("simul_pending_hold", pending, 1);
        check_output("simul_led_on", led_out, 1);
        check_output("simul_busy", busy, 1);
        apply_stimulus(0, 0);
        wait_idle("simul_idle", 200);
        check_output("simul_pending_end", pending, 0);

        // Reset in the fourth ON cycle with two events pending
        expect_pulse(4, -1);
        for (int i = 0; i < 5; i++) apply_stimulus((i % 2) == 0, 0);
        check_output("midrst_pending_pre", pending, 2);
        check_output("midrst_led_pre", led_out, 1);
        n_reset = 1'b0;
        apply_stimulus(0, 0);
        check_output("midrst_led", led_out, 0);
        check_output("midrst_pending", pending, 0);
        check_output("midrst_busy", busy, 0);
        n_reset = 1'b1;
        repeat (30) apply_stimulus(0, 0);
        check_output("midrst_no_resume", busy, 0);

        check_output("pulses_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
